// File: rtl/ctrl_phy_poll.sv
// Autonomous Clause-22 MDIO poller: periodically reads one PHY status register
// and decodes link state and gigabit speed from the returned value.
`timescale 1ns/1ps
module ctrl_phy_poll #(
    parameter int          MDC_DIV       = 2,
    parameter int          POLL_INTERVAL = 250000,
    parameter int          CNT_W         = 24,
    parameter logic [4:0]  STAT_REG      = 5'd17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        poll_en,
    input  logic [4:0]  phy_addr,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    output logic        busy,
    output logic        poll_done,
    output logic        no_phy,
    output logic [15:0] phy_status,
    output logic        link_up,
    output logic        giga_mode
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    localparam int               DIV_W    = $clog2(2 * MDC_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MDC_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * MDC_DIV - 1);
    localparam logic [CNT_W-1:0] INT_LAST = CNT_W'(POLL_INTERVAL - 1);

    state_t             state_r;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [5:0]         bit_cnt_r;
    logic [CNT_W-1:0]   int_cnt_r;
    logic [4:0]         phy_lat_r;
    logic               ta_r;
    logic [15:0]        data_r;
    logic [5:0]         next_bit_s;

    // Value driven on MDIO for a given frame bit; released bits read as 1.
    function automatic logic frame_bit(input logic [5:0] idx, input logic [4:0] ad);
        logic [45:0] hdr;
        hdr = {32'hFFFF_FFFF, 2'b01, 2'b10, ad, STAT_REG};
        if (idx < 6'd46) begin
            frame_bit = hdr[6'd45 - idx];
        end else begin
            frame_bit = 1'b1;
        end
    endfunction

    assign next_bit_s = bit_cnt_r + 6'd1;

    // Poll sequencer: frame timing, pin drive, sampling and status decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= '0;
            bit_cnt_r  <= 6'd0;
            int_cnt_r  <= '0;
            phy_lat_r  <= 5'd0;
            ta_r       <= 1'b1;
            data_r     <= 16'h0000;
            mdc        <= 1'b0;
            mdio_o     <= 1'b1;
            mdio_oe    <= 1'b0;
            busy       <= 1'b0;
            poll_done  <= 1'b0;
            no_phy     <= 1'b0;
            phy_status <= 16'h0000;
            link_up    <= 1'b0;
            giga_mode  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mdc       <= 1'b0;
                    poll_done <= 1'b0;
                    if (poll_en) begin
                        state_r   <= ST_SHIFT;
                        busy      <= 1'b1;
                        phy_lat_r <= phy_addr;
                        bit_cnt_r <= 6'd0;
                        div_cnt_r <= '0;
                        mdio_oe   <= 1'b1;
                        mdio_o    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                        mdio_oe <= 1'b0;
                        mdio_o  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt_r == DIV_LAST) begin
                        // Bit boundary: MDC falls and the next bit is presented.
                        div_cnt_r <= '0;
                        mdc       <= 1'b0;
                        bit_cnt_r <= next_bit_s;
                        if (bit_cnt_r == 6'd63) begin
                            state_r   <= ST_UPDATE;
                            mdio_oe   <= 1'b0;
                            mdio_o    <= 1'b1;
                            poll_done <= 1'b1;
                            if (!ta_r) begin
                                phy_status <= data_r;
                                link_up    <= data_r[10] & data_r[11];
                                giga_mode  <= data_r[10] & data_r[11] & (data_r[15:14] == 2'b10);
                                no_phy     <= 1'b0;
                            end else begin
                                link_up    <= 1'b0;
                                giga_mode  <= 1'b0;
                                no_phy     <= 1'b1;
                            end
                        end else begin
                            mdio_oe <= (next_bit_s < 6'd46);
                            mdio_o  <= frame_bit(next_bit_s, phy_lat_r);
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
                        if (div_cnt_r == DIV_HALF) begin
                            mdc <= 1'b1;
                            if (bit_cnt_r == 6'd47) begin
                                ta_r <= mdio_i;
                            end else if (bit_cnt_r >= 6'd48) begin
                                data_r <= {data_r[14:0], mdio_i};
                            end else begin
                                ta_r <= ta_r;
                            end
                        end else begin
                            mdc <= mdc;
                        end
                    end
                end
                ST_UPDATE: begin
                    poll_done <= 1'b0;
                    busy      <= 1'b0;
                    int_cnt_r <= '0;
                    state_r   <= poll_en ? ST_WAIT : ST_IDLE;
                end
                ST_WAIT: begin
                    if (!poll_en) begin
                        state_r   <= ST_IDLE;
                        int_cnt_r <= '0;
                    end else if (int_cnt_r == INT_LAST) begin
                        int_cnt_r <= '0;
                        state_r   <= ST_SHIFT;
                        busy      <= 1'b1;
                        phy_lat_r <= phy_addr;
                        bit_cnt_r <= 6'd0;
                        div_cnt_r <= '0;
                        mdio_oe   <= 1'b1;
                        mdio_o    <= 1'b1;
                    end else begin
                        int_cnt_r <= int_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    mdc     <= 1'b0;
                    mdio_oe <= 1'b0;
                    mdio_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule
